bus_arbiter: RTL

Round-robin arbiter sharing the single system bus (`pkg::bus_t`, target `DRAM`) between up to four masters, e.g. CPU, VGA fetch and debug port. Sits between the masters and the DRAM controller. It grants one master at a time, registers that master's address, data and direction onto the bus, and waits for the slave's `ready`. It then returns read data with a one-cycle `done` pulse. An optional watchdog aborts transfers whose slave never answers.

---
 rtl/bus_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that shares one system bus between up to
// four masters (e.g. CPU, VGA fetch, debug port) in front of the DRAM
// controller. One master is granted at a time; its address, data and
// direction are registered onto the bus, the arbiter waits for the slave's
// bus_ready, then returns read data with a one-cycle done pulse.
//
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   defined   -> a watchdog aborts a transfer after TIMEOUT unanswered BUS
//                cycles, reporting err=1 with rdata=0 in the done cycle.
//   undefined -> BUS waits for bus_ready indefinitely, err is always 0.
//
// Parameters:
//   N_REQ    number of masters, 2..4
//   TIMEOUT  unanswered BUS cycles before abort (watchdog build only)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req[N_REQ]         per-master request level, held until done
//   we[N_REQ]          per-master direction, 1 = write
//   addr/wdata         master k uses bits [16k+15:16k]
//   gnt[N_REQ]         one-hot, high from grant until done
//   done[N_REQ]        one-hot single-cycle completion pulse
//   err                transfer timed out (with done)
//   rdata              read data, valid in the done cycle
//   bus, bus_we,       registered request to the slave
//   bus_valid
//   bus_ready,         slave completion and read data
//   bus_rdata

package pkg;
  typedef enum logic [1:0] {
    DRAM = 2'd0,
    SRAM = 2'd1,
    IO   = 2'd2,
    ROM  = 2'd3
  } sel_t;

  typedef struct packed {
    logic [15:0] address;
    logic [15:0] data;
    sel_t        sel;
  } bus_t;
endpackage

module bus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [16*N_REQ-1:0] addr,
  input  logic [16*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [15:0]        rdata,
  output pkg::bus_t          bus,
  output logic               bus_we,
  output logic               bus_valid,
  input  logic               bus_ready,
  input  logic [15:0]        bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;
  pkg::bus_t        bus_q, bus_d;
  logic             bus_we_q, bus_we_d;
  logic             bus_valid_q, bus_valid_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  // Inputs widened to the four-master maximum so that a 2-bit master index
  // always selects cleanly, whatever N_REQ is.
  logic [3:0]  req_pad;
  logic [3:0]  we_pad;
  logic [63:0] addr_pad;
  logic [63:0] wdata_pad;

  assign req_pad   = 4'(req);
  assign we_pad    = 4'(we);
  assign addr_pad  = 64'(addr);
  assign wdata_pad = 64'(wdata);

  // Round-robin pick: scan last+1, last+2, ... wrapping mod N_REQ; the first
  // requester found wins. The candidate never exceeds 2*N_REQ-1, so a single
  // conditional subtraction performs the wrap.
  logic       found;
  logic [1:0] pick;
  logic [2:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, last_q} + 3'(i) + 3'd1;
      if (cand >= 3'(N_REQ)) begin
        cand = cand - 3'(N_REQ);
      end
      if (!found && req_pad[cand[1:0]]) begin
        found = 1'b1;
        pick  = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    bus_d       = bus_q;
    bus_we_d    = bus_we_q;
    bus_valid_d = bus_valid_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d = pick;
          for (int k = 0; k < N_REQ; k++) begin
            gnt_d[k] = (2'(k) == pick);
          end
          bus_d.address = addr_pad[{pick, 4'h0} +: 16];
          bus_d.data    = wdata_pad[{pick, 4'h0} +: 16];
          bus_d.sel     = pkg::DRAM;
          bus_we_d      = we_pad[pick];
          bus_valid_d   = 1'b1;
          state_d       = S_BUS;
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end

      S_BUS: begin
        // bus_ready takes priority over a watchdog expiry in the same cycle.
        if (bus_ready) begin
          rdata_d     = bus_rdata;
          bus_valid_d = 1'b0;
          done_d      = gnt_q;
          state_d     = S_DONE;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT)) begin
          rdata_d     = 16'h0000;
          err_d       = 1'b1;
          bus_valid_d = 1'b0;
          done_d      = gnt_q;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      S_DONE: begin
        // Recording the winner as last puts it behind every other pending
        // master in the next arbitration.
        gnt_d   = '0;
        last_d  = win_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= 2'(N_REQ - 1);
      win_q         <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      bus_q.address <= '0;
      bus_q.data    <= '0;
      bus_q.sel     <= pkg::DRAM;
      bus_we_q      <= 1'b0;
      bus_valid_q   <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_q       <= bus_d;
      bus_we_q    <= bus_we_d;
      bus_valid_q <= bus_valid_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus       = bus_q;
  assign bus_we    = bus_we_q;
  assign bus_valid = bus_valid_q;

endmodule
